dbg_abstract_seq: RTL and testbench
===================================

DBG_ABSTRACT_SEQ -- requirements
Module: dbg_abstract_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, bus-wait cycles before timeout (range 2..255).
REQ-002 SHALL have ports: iClk input 1, the single clock; iRst_n input 1, reset (asynchronous, active-low).
REQ-003 SHALL have ports: iCmdValid in 1, start pulse; iCmdType in 8, cmdtype; iAarSize in 3; iPostInc in 1; iPostExec in 1; iTransfer in 1; iWrite in 1; iRegno in 16.
REQ-004 SHALL have ports: iData0 in 32, write data; iHalted in 1, hart halted; iAbort in 1, DM inactive.
REQ-005 SHALL have ports: oBusy out 1; oDone out 1, completion pulse; oCmdErr out 3, error code valid with oDone; oBusyErr out 1, command-while-busy pulse.
REQ-006 SHALL have ports: oData0We out 1; oData0 out 32, read result; oRegnoUpd out 1; oRegnoNext out 16.
REQ-007 SHALL have ports: oRfReq out 1; oRfWe out 1; oRfAddr out 5; oRfWdata out 32; iRfAck in 1; iRfRdata in 32.
REQ-008 SHALL have ports: oCsrReq out 1; oCsrWe out 1; oCsrAddr out 12; oCsrWdata out 32; iCsrAck in 1; iCsrErr in 1; iCsrRdata in 32.

Function
REQ-009 SHALL implement states IDLE, CHECK, REQ, DONE.
REQ-010 IDLE: iCmdValid latches all command fields and iData0, goes to CHECK next cycle; oBusy=1 from the following cycle until DONE exits.
REQ-011 iCmdValid while not IDLE SHALL pulse oBusyErr for one cycle and SHALL NOT alter the command in progress.
REQ-012 CHECK, in priority order, SHALL select oCmdErr: iCmdType!=0 -> 2; iAarSize!=2 -> 2; iPostExec=1 -> 2; iHalted=0 -> 4; transfer and regno not in 0x0000-0x0FFF (CSR) or 0x1000-0x101F (GPR) -> 3. Any error -> DONE.
REQ-013 CHECK with no error and iTransfer=0 SHALL go to DONE with oCmdErr=0 and no bus request.
REQ-014 CHECK with no error and iTransfer=1 SHALL go to REQ. Outputs: oRfAddr=regno[4:0] or oCsrAddr=regno[11:0]; We=iWrite; Wdata=latched data0.
REQ-015 REQ SHALL hold the selected Req, address, We and Wdata stable until the matching Ack; the other port's Req SHALL stay 0.
REQ-016 Ack in REQ SHALL drop Req the next cycle and go to DONE. Read: oData0We pulses with oData0=rdata. iCsrErr with iCsrAck -> oCmdErr=3, no oData0We.
REQ-017 DONE SHALL last one cycle: oDone=1 and oCmdErr valid, then IDLE. If iPostInc=1 and oCmdErr=0, oRegnoUpd=1 with oRegnoNext=regno+1 (16-bit wrap, 0xFFFF->0x0000).
REQ-018 Ack arriving outside REQ SHALL be ignored.
REQ-019 iAbort=1 SHALL force IDLE next cycle from any state: Req and pulses drop, no oDone.
REQ-020 iAbort and iCmdValid in the same cycle: abort wins; command dropped.
REQ-021 Sequence latency: CHECK to DONE is 1 cycle without transfer; with transfer, 2 cycles plus ack wait.

Reset
REQ-022 Reset SHALL force IDLE. All outputs SHALL be 0: oBusy, oDone, oCmdErr, oBusyErr, oData0We, oData0, oRegnoUpd, oRegnoNext, and all Req, We, Addr and Wdata.
REQ-023 Reset asserted mid-REQ SHALL drop Req asynchronously. After release, no completion is reported.

Configuration
REQ-024 Macro DBG_ABSTRACT_TIMEOUT_EN defined: an 8-bit counter clears on REQ entry and increments each REQ cycle without Ack. At TIMEOUT_CYCLES without Ack: Req drops, DONE, oCmdErr=5.
REQ-025 Macro undefined: no counter; REQ waits indefinitely for Ack (abort/reset only exits).

Verification
REQ-026 Halted, GPR read regno=0x1005, iRfAck after 3 cycles, iRfRdata=0xDEADBEEF -> oRfAddr=5, oData0=0xDEADBEEF, oDone with oCmdErr=0.
REQ-027 CSR write regno=0x0300, data0=0x1888, iPostInc=1, ack with iCsrErr=1 -> oCsrWe=1, oCmdErr=3, no oRegnoUpd.
REQ-028 iHalted=0, any transfer -> oCmdErr=4 on oDone, 2 cycles after iCmdValid, no Req.
REQ-029 iAarSize=3 -> oCmdErr=2. regno=0xFFFF, transfer=0, postinc -> oRegnoNext=0x0000, oCmdErr=0.
REQ-030 iCmdValid during REQ -> oBusyErr pulse, original completes unchanged. iAbort in REQ -> Req=0 next cycle, no oDone.
REQ-031 With DBG_ABSTRACT_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> Req drops after 4 cycles, oCmdErr=5.

Source files
------------

// File: rtl/dbg_abstract_seq.sv
// Abstract-command sequencer: IDLE->CHECK->DONE (1 cycle) or IDLE->CHECK->REQ->DONE (2 cycles + ack wait); single RF/CSR request held until ack.
// No backpressure on commands (busy error pulse instead); iAbort forces IDLE. Optional REQ timeout via DBG_ABSTRACT_TIMEOUT_EN.
module dbg_abstract_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic        iCmdValid,
   input  logic [7:0]  iCmdType,
   input  logic [2:0]  iAarSize,
   input  logic        iPostInc,
   input  logic        iPostExec,
   input  logic        iTransfer,
   input  logic        iWrite,
   input  logic [15:0] iRegno,
   input  logic [31:0] iData0,
   input  logic        iHalted,
   input  logic        iAbort,
   output logic        oBusy,
   output logic        oDone,
   output logic [2:0]  oCmdErr,
   output logic        oBusyErr,
   output logic        oData0We,
   output logic [31:0] oData0,
   output logic        oRegnoUpd,
   output logic [15:0] oRegnoNext,
   output logic        oRfReq,
   output logic        oRfWe,
   output logic [4:0]  oRfAddr,
   output logic [31:0] oRfWdata,
   input  logic        iRfAck,
   input  logic [31:0] iRfRdata,
   output logic        oCsrReq,
   output logic        oCsrWe,
   output logic [11:0] oCsrAddr,
   output logic [31:0] oCsrWdata,
   input  logic        iCsrAck,
   input  logic        iCsrErr,
   input  logic [31:0] iCsrRdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, REQ = 2'd2, DONE = 2'd3} state_t;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_tmo_range
      $error("TIMEOUT_CYCLES must be within 2..255");
   end

   state_t      state;
   logic [7:0]  cmd_type;
   logic [2:0]  aar_size;
   logic        post_inc, post_exec, transfer, write;
   logic [15:0] regno;
   logic [31:0] data0;

   logic        is_csr, is_gpr, rf_hit, csr_hit, fin, rd_upd;
   logic [2:0]  check_err, fin_err;
   logic [31:0] rd_data;

   assign is_csr  = (regno[15:12] == 4'h0);
   assign is_gpr  = (regno[15:5] == 11'h080);
   // Only the ack of the port actually requested counts; anything else is ignored.
   assign rf_hit  = (state == REQ) && oRfReq && iRfAck;
   assign csr_hit = (state == REQ) && oCsrReq && iCsrAck;
   assign rd_data = rf_hit ? iRfRdata : iCsrRdata;

`ifdef DBG_ABSTRACT_TIMEOUT_EN
   logic [7:0] tmo_cnt;
   logic       tmo_hit;
   assign tmo_hit = (state == REQ) && !rf_hit && !csr_hit && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      check_err = 3'd0;
      if (cmd_type != 8'd0 || aar_size != 3'd2 || post_exec)
         check_err = 3'd2;
      else if (!iHalted)
         check_err = 3'd4;
      else if (transfer && !is_csr && !is_gpr)
         check_err = 3'd3;
   end

   always_comb begin
      fin     = 1'b0;
      fin_err = 3'd0;
      rd_upd  = 1'b0;
      case (state)
         CHECK: begin
            if (check_err != 3'd0 || !transfer) begin
               fin     = 1'b1;
               fin_err = check_err;
            end
         end
         REQ: begin
            if (rf_hit || csr_hit) begin
               fin     = 1'b1;
               fin_err = (csr_hit && iCsrErr) ? 3'd3 : 3'd0;
               rd_upd  = !write && !(csr_hit && iCsrErr);
            end
`ifdef DBG_ABSTRACT_TIMEOUT_EN
            else if (tmo_hit) begin
               fin     = 1'b1;
               fin_err = 3'd5;
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state      <= IDLE;
         cmd_type   <= '0;
         aar_size   <= '0;
         post_inc   <= 1'b0;
         post_exec  <= 1'b0;
         transfer   <= 1'b0;
         write      <= 1'b0;
         regno      <= '0;
         data0      <= '0;
         oBusy      <= 1'b0;
         oDone      <= 1'b0;
         oCmdErr    <= '0;
         oBusyErr   <= 1'b0;
         oData0We   <= 1'b0;
         oData0     <= '0;
         oRegnoUpd  <= 1'b0;
         oRegnoNext <= '0;
         oRfReq     <= 1'b0;
         oRfWe      <= 1'b0;
         oRfAddr    <= '0;
         oRfWdata   <= '0;
         oCsrReq    <= 1'b0;
         oCsrWe     <= 1'b0;
         oCsrAddr   <= '0;
         oCsrWdata  <= '0;
`ifdef DBG_ABSTRACT_TIMEOUT_EN
         tmo_cnt    <= '0;
`endif
      end else begin
         oDone     <= 1'b0;
         oBusyErr  <= 1'b0;
         oData0We  <= 1'b0;
         oRegnoUpd <= 1'b0;
         if (iAbort) begin
            state   <= IDLE;
            oBusy   <= 1'b0;
            oRfReq  <= 1'b0;
            oCsrReq <= 1'b0;
         end else begin
            oBusyErr <= iCmdValid && (state != IDLE);
            if (fin) begin
               state      <= DONE;
               oDone      <= 1'b1;
               oCmdErr    <= fin_err;
               oRfReq     <= 1'b0;
               oCsrReq    <= 1'b0;
               oData0We   <= rd_upd;
               if (rd_upd)
                  oData0  <= rd_data;
               oRegnoUpd  <= post_inc && (fin_err == 3'd0);
               oRegnoNext <= regno + 16'd1;
            end else begin
               case (state)
                  IDLE: begin
                     if (iCmdValid) begin
                        state     <= CHECK;
                        oBusy     <= 1'b1;
                        cmd_type  <= iCmdType;
                        aar_size  <= iAarSize;
                        post_inc  <= iPostInc;
                        post_exec <= iPostExec;
                        transfer  <= iTransfer;
                        write     <= iWrite;
                        regno     <= iRegno;
                        data0     <= iData0;
                     end
                  end
                  CHECK: begin
                     // Reaching here means a legal transfer: regno is either a GPR or a CSR.
                     state <= REQ;
                     if (is_gpr) begin
                        oRfReq   <= 1'b1;
                        oRfWe    <= write;
                        oRfAddr  <= regno[4:0];
                        oRfWdata <= data0;
                     end else begin
                        oCsrReq   <= 1'b1;
                        oCsrWe    <= write;
                        oCsrAddr  <= regno[11:0];
                        oCsrWdata <= data0;
                     end
`ifdef DBG_ABSTRACT_TIMEOUT_EN
                     tmo_cnt <= '0;
`endif
                  end
                  REQ: begin
`ifdef DBG_ABSTRACT_TIMEOUT_EN
                     tmo_cnt <= tmo_cnt + 8'd1;
`endif
                  end
                  DONE: begin
                     state <= IDLE;
                     oBusy <= 1'b0;
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_dbg_abstract_seq.sv
// Randomized bench for dbg_abstract_seq: a per-cycle timeline of expected outputs is planned from command-level rules.
module tb_dbg_abstract_seq;
   localparam int TMO = 4;
   localparam int NC  = 4096;
`ifdef DBG_ABSTRACT_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic iClk = 1'b0;
   logic iRst_n;
   logic iCmdValid, iPostInc, iPostExec, iTransfer, iWrite, iHalted, iAbort;
   logic [7:0] iCmdType;
   logic [2:0] iAarSize;
   logic [15:0] iRegno;
   logic [31:0] iData0, iRfRdata, iCsrRdata;
   logic iRfAck, iCsrAck, iCsrErr;
   logic oBusy, oDone, oBusyErr, oData0We, oRegnoUpd, oRfReq, oRfWe, oCsrReq, oCsrWe;
   logic [2:0] oCmdErr;
   logic [31:0] oData0, oRfWdata, oCsrWdata;
   logic [15:0] oRegnoNext;
   logic [4:0] oRfAddr;
   logic [11:0] oCsrAddr;

   always #5 iClk = ~iClk;

   dbg_abstract_seq #(.TIMEOUT_CYCLES(TMO)) dut (
      .iClk(iClk), .iRst_n(iRst_n), .iCmdValid(iCmdValid), .iCmdType(iCmdType),
      .iAarSize(iAarSize), .iPostInc(iPostInc), .iPostExec(iPostExec), .iTransfer(iTransfer),
      .iWrite(iWrite), .iRegno(iRegno), .iData0(iData0), .iHalted(iHalted), .iAbort(iAbort),
      .oBusy(oBusy), .oDone(oDone), .oCmdErr(oCmdErr), .oBusyErr(oBusyErr),
      .oData0We(oData0We), .oData0(oData0), .oRegnoUpd(oRegnoUpd), .oRegnoNext(oRegnoNext),
      .oRfReq(oRfReq), .oRfWe(oRfWe), .oRfAddr(oRfAddr), .oRfWdata(oRfWdata),
      .iRfAck(iRfAck), .iRfRdata(iRfRdata),
      .oCsrReq(oCsrReq), .oCsrWe(oCsrWe), .oCsrAddr(oCsrAddr), .oCsrWdata(oCsrWdata),
      .iCsrAck(iCsrAck), .iCsrErr(iCsrErr), .iCsrRdata(iCsrRdata)
   );

   typedef struct {
      bit vld; bit [7:0] ctype; bit [2:0] size; bit pinc, pexec, xfer, wr;
      bit [15:0] regno; bit [31:0] d0; bit halted, abort, rfack, csrack, csrerr; bit [31:0] rdata;
   } stim_t;
   stim_t stim[NC];

   // Expected timeline, indexed by clock edges since reset release.
   bit e_busy[NC], e_done[NC], e_berr[NC], e_rfreq[NC], e_csrreq[NC], e_we[NC], e_d0we[NC], e_upd[NC];
   bit [2:0] e_err[NC];
   bit [15:0] e_addr[NC], e_next[NC];
   bit [31:0] e_wdata[NC], e_d0[NC];

   logic o_busy[NC], o_done[NC], o_berr[NC], o_rfreq[NC], o_csrreq[NC], o_csrwe[NC], o_d0we[NC], o_upd[NC];
   logic [2:0] o_err[NC];
   logic [4:0] o_rfaddr[NC];
   logic [15:0] o_next[NC];
   logic [31:0] o_d0[NC];

   int tests, fails, cyc, cur, nxt, run_len;
   bit chk_en;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // Plans one command issued at cycle n: stimulus plus every expected output it causes.
   task automatic plan_cmd(input int n, input bit [7:0] ctype, input bit [2:0] size, input bit pinc,
                           input bit pexec, input bit xfer, input bit wr, input bit [15:0] regno,
                           input bit [31:0] d0, input bit halted, input int w, input bit [31:0] rdata,
                           input bit cerr, input int stray_off, input int abort_off, output int nx);
      int d, last, a, m;
      bit [2:0] err;
      bit do_req, gpr, tmo, aborted;
      err = 3'd0;
      if (ctype != 0 || size != 3'd2 || pexec) err = 3'd2;
      else if (!halted) err = 3'd4;
      else if (xfer && regno > 16'h101F) err = 3'd3;
      do_req = xfer && (err == 0);
      gpr    = regno >= 16'h1000;
      tmo    = do_req && TMO_EN && (w >= TMO);
      if (!do_req) d = n + 2;
      else if (tmo) d = n + 2 + TMO;
      else d = n + 3 + w;
      if (do_req && !tmo && !gpr && cerr) err = 3'd3;
      if (tmo) err = 3'd5;
      a = (abort_off >= 0) ? n + (abort_off % (d - n)) : -1;
      aborted = (a >= n);
      last = aborted ? a : d;

      stim[n].vld = 1; stim[n].ctype = ctype; stim[n].size = size; stim[n].pinc = pinc;
      stim[n].pexec = pexec; stim[n].xfer = xfer; stim[n].wr = wr; stim[n].regno = regno;
      stim[n].d0 = d0; stim[n+1].halted = halted;
      if (aborted) stim[a].abort = 1;
      for (int i = n + 1; i <= last; i++) e_busy[i] = 1;
      if (do_req)
         for (int i = n + 2; i <= (aborted ? a : d - 1); i++) begin
            if (gpr) e_rfreq[i] = 1; else e_csrreq[i] = 1;
            e_addr[i] = regno; e_we[i] = wr; e_wdata[i] = d0;
         end
      if (!aborted) begin
         e_done[d] = 1; e_err[d] = err;
         if (do_req && !wr && err == 0) begin e_d0we[d] = 1; e_d0[d] = rdata; end
         if (pinc && err == 0) begin e_upd[d] = 1; e_next[d] = regno + 16'd1; end
         if (do_req && !tmo) begin
            if (gpr) stim[n+2+w].rfack = 1; else stim[n+2+w].csrack = 1;
            stim[n+2+w].csrerr = cerr; stim[n+2+w].rdata = rdata;
         end
      end
      // Acks that must be ignored: matching port during CHECK, other port while waiting.
      if ($urandom_range(0, 2) == 0) begin
         if (gpr) stim[n+1].rfack = 1; else stim[n+1].csrack = 1;
         stim[n+1].rdata = $urandom;
      end
      for (int i = n + 2; i <= n + 1 + w && i <= last; i++)
         if ($urandom_range(0, 2) == 0) begin
            if (gpr) stim[i].csrack = 1; else stim[i].rfack = 1;
            stim[i].rdata = $urandom; stim[i].csrerr = 1'($urandom);
         end
      if (stray_off >= 0 && last > n) begin
         m = n + 1 + (stray_off % (last - n));
         if (!(aborted && m == a)) begin
            stim[m].vld = 1; stim[m].ctype = 8'($urandom); stim[m].size = 3'($urandom);
            stim[m].pinc = 1'($urandom); stim[m].xfer = 1'($urandom); stim[m].wr = 1'($urandom);
            stim[m].regno = 16'($urandom); stim[m].d0 = $urandom;
            e_berr[m+1] = 1;
         end
      end
      nx = last + 1;
   endtask

   task automatic apply(input int c);
      iCmdValid = stim[c].vld;   iCmdType = stim[c].ctype;  iAarSize = stim[c].size;
      iPostInc  = stim[c].pinc;  iPostExec = stim[c].pexec; iTransfer = stim[c].xfer;
      iWrite    = stim[c].wr;    iRegno = stim[c].regno;    iData0 = stim[c].d0;
      iHalted   = stim[c].halted; iAbort = stim[c].abort;
      iRfAck    = stim[c].rfack; iCsrAck = stim[c].csrack;  iCsrErr = stim[c].csrerr;
      iRfRdata  = stim[c].rdata; iCsrRdata = stim[c].rdata;
   endtask

   always @(posedge iClk or negedge iRst_n)
      if (!iRst_n) cyc <= 0; else cyc <= cyc + 1;

   always @(negedge iClk) begin : cmp
      int c;
      if (chk_en) begin
         c = cyc;
         o_busy[c] = oBusy; o_done[c] = oDone; o_err[c] = oCmdErr; o_berr[c] = oBusyErr;
         o_rfreq[c] = oRfReq; o_rfaddr[c] = oRfAddr; o_csrreq[c] = oCsrReq; o_csrwe[c] = oCsrWe;
         o_d0we[c] = oData0We; o_d0[c] = oData0; o_upd[c] = oRegnoUpd; o_next[c] = oRegnoNext;
         chk("busy", oBusy, e_busy[c]);
         chk("done", oDone, e_done[c]);
         if (e_done[c]) chk("cmderr", oCmdErr, e_err[c]);
         chk("busyerr", oBusyErr, e_berr[c]);
         chk("rfreq", oRfReq, e_rfreq[c]);
         chk("csrreq", oCsrReq, e_csrreq[c]);
         if (e_rfreq[c]) begin
            chk("rfaddr", oRfAddr, e_addr[c][4:0]);
            chk("rfwe", oRfWe, e_we[c]);
            chk("rfwdata", oRfWdata, e_wdata[c]);
         end
         if (e_csrreq[c]) begin
            chk("csraddr", oCsrAddr, e_addr[c][11:0]);
            chk("csrwe", oCsrWe, e_we[c]);
            chk("csrwdata", oCsrWdata, e_wdata[c]);
         end
         chk("data0we", oData0We, e_d0we[c]);
         if (e_d0we[c]) chk("data0", oData0, e_d0[c]);
         chk("regnoupd", oRegnoUpd, e_upd[c]);
         if (e_upd[c]) chk("regnonext", oRegnoNext, e_next[c]);
      end
   end

   initial begin
      bit [15:0] rg;
      tests = 0; fails = 0; chk_en = 0; iRst_n = 0;
      apply(0);
      // Directed commands first (cycle numbers are pinned below), then random traffic.
      plan_cmd(5,  0, 2, 0, 0, 1, 0, 16'h1005, 32'h0, 1, 3, 32'hDEADBEEF, 0, -1, -1, nxt);
      plan_cmd(12, 0, 2, 1, 0, 1, 1, 16'h0300, 32'h1888, 1, 1, 32'h0, 1, -1, -1, nxt);
      plan_cmd(17, 0, 2, 0, 0, 1, 0, 16'h1001, 32'h0, 0, 0, 32'h0, 0, -1, -1, nxt);
      plan_cmd(20, 0, 3, 0, 0, 1, 0, 16'h1002, 32'h0, 1, 0, 32'h0, 0, -1, -1, nxt);
      plan_cmd(23, 0, 2, 1, 0, 0, 0, 16'hFFFF, 32'h0, 1, 0, 32'h0, 0, -1, -1, nxt);
      plan_cmd(26, 0, 2, 0, 0, 1, 1, 16'h1010, 32'h12345678, 1, 2, 32'h0, 0, 2, -1, nxt);
      plan_cmd(34, 0, 2, 0, 0, 1, 0, 16'h07B0, 32'h0, 1, 10, 32'h55AA55AA, 0, -1, 4, nxt);
      plan_cmd(39, 0, 2, 0, 0, 0, 0, 16'h0010, 32'h0, 1, 0, 32'h0, 0, -1, 0, nxt);
      cur = 40;
`ifdef DBG_ABSTRACT_TIMEOUT_EN
      plan_cmd(40, 0, 2, 0, 0, 1, 0, 16'h1003, 32'h0, 1, 20, 32'h0, 0, -1, -1, nxt);
      cur = 47;
`endif
      while (cur < NC - 64) begin
         case ($urandom_range(0, 2))
            0: rg = 16'($urandom_range(0, 16'h0FFF));
            1: rg = 16'h1000 + 16'($urandom_range(0, 31));
            default: rg = 16'($urandom_range(16'h1020, 16'hFFFF));
         endcase
         plan_cmd(cur, ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                  ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd2,
                  1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                  rg, $urandom, $urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1,
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : -1, nxt);
         cur = nxt + $urandom_range(0, 2);
      end
      run_len = cur + 5;

      repeat (3) @(posedge iClk);
      @(negedge iClk);
      chk("rst_busy", oBusy, 0);       chk("rst_done", oDone, 0);
      chk("rst_cmderr", oCmdErr, 0);   chk("rst_busyerr", oBusyErr, 0);
      chk("rst_d0we", oData0We, 0);    chk("rst_d0", oData0, 0);
      chk("rst_upd", oRegnoUpd, 0);    chk("rst_next", oRegnoNext, 0);
      chk("rst_rfreq", oRfReq, 0);     chk("rst_rfwe", oRfWe, 0);
      chk("rst_rfaddr", oRfAddr, 0);   chk("rst_rfwdata", oRfWdata, 0);
      chk("rst_csrreq", oCsrReq, 0);   chk("rst_csrwe", oCsrWe, 0);
      chk("rst_csraddr", oCsrAddr, 0); chk("rst_csrwdata", oCsrWdata, 0);
      iRst_n = 1;
      #1 chk_en = 1;
      for (int k = 0; k < run_len; k++) begin
         @(posedge iClk); #1;
         apply(cyc);
      end
      @(negedge iClk); #1;
      chk_en = 0;

      chk("gpr_rd_req", o_rfreq[7], 1);        chk("gpr_rd_addr", o_rfaddr[7], 5);
      chk("gpr_rd_wait", o_done[10], 0);       chk("gpr_rd_done", o_done[11], 1);
      chk("gpr_rd_err", o_err[11], 0);         chk("gpr_rd_we", o_d0we[11], 1);
      chk("gpr_rd_data", o_d0[11], 32'hDEADBEEF); chk("gpr_rd_reqdrop", o_rfreq[11], 0);
      chk("csr_wr_req", o_csrreq[14], 1);      chk("csr_wr_we", o_csrwe[14], 1);
      chk("csr_wr_done", o_done[16], 1);       chk("csr_wr_err", o_err[16], 3);
      chk("csr_wr_noupd", o_upd[16], 0);
      chk("nohalt_done", o_done[19], 1);       chk("nohalt_err", o_err[19], 4);
      chk("nohalt_noreq", o_rfreq[18], 0);
      chk("size3_done", o_done[22], 1);        chk("size3_err", o_err[22], 2);
      chk("wrap_done", o_done[25], 1);         chk("wrap_err", o_err[25], 0);
      chk("wrap_upd", o_upd[25], 1);           chk("wrap_next", o_next[25], 0);
      chk("busyerr_pulse", o_berr[30], 1);     chk("busyerr_done", o_done[31], 1);
      chk("busyerr_err", o_err[31], 0);
      chk("abort_req_before", o_csrreq[38], 1); chk("abort_req_after", o_csrreq[39], 0);
      chk("abort_idle", o_busy[39], 0);        chk("abort_nodone", o_done[39], 0);
      chk("abort_cmd_dropped", o_busy[40], 0); chk("abort_cmd_nodone", o_done[41], 0);
`ifdef DBG_ABSTRACT_TIMEOUT_EN
      chk("tmo_req_last", o_rfreq[45], 1);     chk("tmo_req_drop", o_rfreq[46], 0);
      chk("tmo_done", o_done[46], 1);          chk("tmo_err", o_err[46], 5);
`endif

      // Reset arriving while a request is outstanding.
      apply(0);
      @(posedge iClk); #1;
      iCmdValid = 1; iRegno = 16'h1002; iAarSize = 3'd2; iTransfer = 1; iHalted = 1;
      @(posedge iClk); #1;
      iCmdValid = 0;
      @(posedge iClk); #1;
      chk("midreq_req", oRfReq, 1);
      #2 iRst_n = 0;
      #1 chk("midreq_async_drop", oRfReq, 0);
      chk("midreq_async_busy", oBusy, 0);
      @(negedge iClk);
      iRst_n = 1;
      for (int k = 0; k < 6; k++) begin
         @(posedge iClk); #1;
         iRfAck = 1;
         @(negedge iClk);
         chk("midreq_no_done", oDone, 0);
         chk("midreq_no_req", oRfReq, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
